// File: rtl/shifter_pkg.sv
// shifter_pkg: FSM state type and shift-direction codes shared by the shifter blocks
package shifter_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} estado_t;
    localparam logic DIR_IZQ = 1'b0;
    localparam logic DIR_DER = 1'b1;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational one-position shift, left logical or right logical/arithmetic
module shift_step
    import shifter_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic         dir,
    input  logic         arith,
    output logic [N-1:0] y,
    output logic         bit_out
);
    always_comb begin
        y       = (dir == DIR_IZQ) ? {a[N-2:0], 1'b0} : {arith & a[N-1], a[N-1:1]};
        bit_out = (dir == DIR_IZQ) ? a[N-1] : a[0];
    end
endmodule

// File: rtl/shifter_secuencial.sv
// shifter_secuencial: multi-position shifter iterating one shift_step per clock
module shifter_secuencial
    import shifter_pkg::*;
#(
    parameter int N  = 8,
    parameter int AW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          dir,
    input  logic          arith,
    input  logic [N-1:0]  data_in,
    input  logic [AW-1:0] amount,
    output logic [N-1:0]  data_out,
    output logic          carry_out,
    output logic          busy,
    output logic          done
);
    estado_t       state;
    logic [AW-1:0] cnt, cnt_ini;
    logic          dir_q, arith_q, step_bit;
    logic [N-1:0]  step_y;
    always_comb cnt_ini = (amount > AW'(N)) ? AW'(N) : amount;
    shift_step #(.N(N)) u_step (
        .a(data_out), .dir(dir_q), .arith(arith_q), .y(step_y), .bit_out(step_bit)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            data_out  <= '0;
            carry_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            dir_q     <= DIR_IZQ;
            arith_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    data_out  <= data_in;
                    dir_q     <= dir;
                    arith_q   <= arith;
                    carry_out <= 1'b0;
                    cnt       <= cnt_ini;
                    busy      <= 1'b1;
                    done      <= (cnt_ini == '0);
                    state     <= (cnt_ini == '0) ? DONE : SHIFT;
                end
                SHIFT: begin
                    data_out  <= step_y;
                    carry_out <= step_bit;
                    cnt       <= cnt - 1'b1;
                    done      <= (cnt == AW'(1));
                    state     <= (cnt == AW'(1)) ? DONE : SHIFT;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
